// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver with mid-bit sampling, optional parity and
// one or two stop bits. Received words are presented through a valid/ready
// hold register. A frame that completes while the previous word is still
// held (and not being accepted) is dropped, and overrun pulses.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   u_rx               serial line (idle high, asynchronous to clk)
//   en_rx              allows new start bits to be detected
//   data               received word, first line bit in the LSB
//   rx_valid/rx_ready  hold-register handshake
//   parity_err         parity mismatch on the held word
//   frame_err          a stop bit of the held word was sampled low
//   overrun            one-cycle pulse when a completed frame was dropped
//   busy               receiver is not idle
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | line idle, waiting for a falling edge while en_rx = 1
// ST_START | confirming the start bit at its middle
// ST_DATA  | sampling data bits at mid-bit, LSB first
// ST_PARITY| sampling the parity bit
// ST_STOP  | sampling stop bit(s); the last sample completes the frame
module uart_rx_core #(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD_RATE   = 19200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 u_rx,
    input  logic                 en_rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic [1:0]           sync_q;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_acc_q, perr_acc_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;

    logic rx_s;
    logic baud_end;
    logic done;
    logic stop_bad;

    assign rx_s     = sync_q[1];
    assign baud_end = (baud_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        perr_acc_d   = perr_acc_q;
        ferr_acc_d   = ferr_acc_q;
        data_d       = data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        done         = 1'b0;
        stop_bad     = ferr_acc_q;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!rx_s && en_rx) begin
                    state_d    = ST_START;
                    perr_acc_d = 1'b0;
                    ferr_acc_d = 1'b0;
                end
            end
            ST_START: begin
                if (baud_q == CNT_HALF) begin
                    // Counter restarts here, so later samples land mid-bit.
                    baud_d  = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    // Shift in from the top: the first bit ends up in the LSB.
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (baud_end) begin
                    baud_d     = '0;
                    state_d    = ST_STOP;
                    perr_acc_d = (PARITY_MODE == 2) ? (rx_s == ^shreg_q)
                                                    : (rx_s != ^shreg_q);
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!rx_s) begin
                        ferr_acc_d = 1'b1;
                    end
                    if (bit_q == STOP_LAST) begin
                        // Return mid-stop-bit so the next start edge is caught.
                        bit_d    = '0;
                        state_d  = ST_IDLE;
                        done     = 1'b1;
                        stop_bad = ferr_acc_q | ~rx_s;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        if (done) begin
            if (!rx_valid_q || rx_ready) begin
                data_d       = shreg_q;
                parity_err_d = perr_acc_q;
                frame_err_d  = stop_bad;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q       <= 2'b11;
            state_q      <= ST_IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            perr_acc_q   <= 1'b0;
            ferr_acc_q   <= 1'b0;
            data_q       <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], u_rx};
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            perr_acc_q   <= perr_acc_d;
            ferr_acc_q   <= ferr_acc_d;
            data_q       <= data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign data       = data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter CLK_FREQ, 50000000: system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, 19200: line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division, SHALL be >= 4).
REQ-003 Parameter DATA_BITS, 8: data bits per frame, legal range 5..9.
REQ-004 Parameter PARITY_MODE, 1: 0 = none, 1 = even, 2 = odd.
REQ-005 Parameter STOP_BITS, 1: stop bits per frame, 1 or 2.
REQ-006 Port clk, input, 1: single clock; all state SHALL be on its rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Port u_rx, input, 1: serial line, idle high, asynchronous to clk.
REQ-009 Port en_rx, input, 1: receive enable; gates detection of new start bits only.
REQ-010 Port data, output, DATA_BITS: received word, LSB first on the line.
REQ-011 Port rx_valid, output, 1: data/parity_err/frame_err hold a word not yet accepted.
REQ-012 Port rx_ready, input, 1: consumer accepts the word when rx_valid && rx_ready.
REQ-013 Port parity_err, output, 1: parity mismatch on the held word; 0 when PARITY_MODE = 0.
REQ-014 Port frame_err, output, 1: at least one stop bit sampled low on the held word.
REQ-015 Port overrun, output, 1: one-cycle pulse when a completed frame was dropped.
REQ-016 Port busy, output, 1: high in every state except IDLE.

Function
REQ-017 u_rx SHALL pass through a 2-flop synchroniser (flops reset to 1); all logic uses the synchronised value rx_s.
REQ-018 States SHALL be IDLE, START, DATA, PARITY, STOP; a baud counter (0..CLKS_PER_BIT-1) and bit counter drive the transitions.
REQ-019 IDLE -> START when rx_s = 0 and en_rx = 1; baud counter cleared.
REQ-020 START: at count CLKS_PER_BIT/2 - 1 sample rx_s; 1 -> glitch, return to IDLE with no flags; 0 -> DATA, baud counter cleared.
REQ-021 DATA: sample rx_s every CLKS_PER_BIT cycles (mid-bit) into bit index 0..DATA_BITS-1 in order; after last bit -> PARITY if PARITY_MODE != 0, else STOP.
REQ-022 PARITY: sample one bit; error if sample != XOR(data) (even) or != ~XOR(data) (odd); -> STOP.
REQ-023 STOP: sample STOP_BITS bits at mid-bit; any 0 sets the frame error; after last stop sample -> IDLE.
REQ-024 Frame completion = cycle of the last stop sample; data, parity_err, frame_err, rx_valid SHALL update on the next rising edge (latency 1 clk).
REQ-025 Frames with parity or framing errors SHALL still be delivered, with flags set.
REQ-026 rx_valid SHALL stay high and data/flags stable until a cycle with rx_ready = 1; then clear on the next edge.
REQ-027 Completion while rx_valid = 1 and rx_ready = 0: new frame discarded, held word unchanged, overrun pulses 1 cycle.
REQ-028 Completion in the same cycle as a handshake: new word loaded, rx_valid stays 1, no overrun.
REQ-029 en_rx falling mid-frame SHALL NOT abort the frame; it only blocks the next IDLE -> START.
REQ-030 A frame may start in the cycle after returning to IDLE (back-to-back frames, mid-stop-bit resync).

Reset
REQ-031 rst high SHALL force IDLE, all counters 0, data 0, rx_valid 0, parity_err 0, frame_err 0, overrun 0, busy 0, synchroniser 1, immediately and independent of clk.
REQ-032 rst asserted mid-frame SHALL discard the partial frame; after release, reception restarts at the next start bit.

Verification (CLK_FREQ=16, BAUD_RATE=1, i.e. 16 clk/bit, unless stated)
REQ-033 8E1, send 0xA5 parity 0 stop 1, rx_ready=0 -> data=0xA5, rx_valid=1, parity_err=0, frame_err=0, held until rx_ready pulse.
REQ-034 8O1, send 0x3C with parity 0 (wrong) -> data=0x3C, parity_err=1; then 8N1 with stop bit 0 -> frame_err=1.
REQ-035 Low pulse of 5 clk on idle line -> state returns to IDLE, rx_valid stays 0, busy high only during the glitch window.
REQ-036 Two back-to-back frames 0x11, 0x22 with rx_ready=0 -> data remains 0x11, overrun pulses exactly once; with rx_ready=1 held -> both delivered, no overrun.
REQ-037 DATA_BITS=5, STOP_BITS=2, send 0x15 with second stop bit 0 -> data=5'h15, frame_err=1.
REQ-038 rst pulsed after bit 3 of a frame, then full frame 0x5A -> all outputs 0 during reset, then data=0x5A, rx_valid=1.
